bram_stream_writer: RTL and testbench
=====================================

Name: bram_stream_writer

Overview:
- Writer-side counterpart to the byte-wide block-memory read path: accepts a valid/ready byte stream and writes it into a single-port block RAM (addra/dina/wea/douta, 8-bit data, 16-bit address).
- Writes sequentially from a programmed base address.
- Optionally reads the region back and compares an 8-bit additive checksum of read data against the written data.
- Sits between a loader (UART/host stream) and the BRAM instance used by the image/ROM paths.

Parameters:
- ADDR_W, 16, BRAM address width.
- DATA_W, 8, BRAM data width.
- MAX_ADDR, 61440, highest legal BRAM address; depth is MAX_ADDR+1.
- RD_LAT, 1, BRAM read latency in clocks, from addra to douta valid (1..3).

Ports:
- clk  in  1  single clock; also drives the BRAM clka.
- rst_n  in  1  asynchronous active-low reset.
- start  in  1  one-cycle command strobe; ignored unless IDLE.
- base_addr  in  ADDR_W  first write address, sampled on start.
- length  in  ADDR_W+1  number of bytes, sampled on start.
- verify_en  in  1  run readback checksum after writing, sampled on start.
- in_data  in  DATA_W  stream byte.
- in_valid  in  1  stream byte valid.
- in_ready  out  1  writer accepts byte this cycle.
- addra  out  ADDR_W  BRAM address.
- dina  out  DATA_W  BRAM write data.
- wea  out  1  BRAM write enable.
- douta  in  DATA_W  BRAM read data.
- busy  out  1  command in progress.
- done  out  1  one-cycle completion pulse.
- err_range  out  1  last command rejected (range/length).
- verify_ok  out  1  last verify passed; valid when done=1 and verify_en was set.
- bytes_written  out  ADDR_W+1  bytes written by last/current command.

Behaviour:
- Reset (async, rst_n=0): state IDLE.
  - All outputs 0: in_ready, addra, dina, wea, busy, done, err_range, verify_ok, bytes_written.
  - wea drops immediately, no clock needed.
  - Counters and checksums cleared.
- States: IDLE, WRITE, VERIFY, DRAIN, FIN.
- IDLE + start:
  - Latch base_addr, length, verify_en.
  - Clear bytes_written, both checksums and err_range.
  - length==0 -> FIN; no BRAM access; verify_ok=1 if verify_en.
  - base_addr+length-1 > MAX_ADDR, computed in ADDR_W+2 bits so no wrap -> err_range=1, FIN; no BRAM access.
  - Otherwise -> WRITE, with busy=1 and in_ready=1 from the next cycle.
- WRITE:
  - A beat is accepted when in_valid && in_ready.
  - On each accepted beat, registered: addra<=cur_addr, dina<=in_data, wea<=1; cur_addr+1; bytes_written+1; wr_sum<=wr_sum+in_data (mod 256).
  - On a non-accepted cycle: wea<=0; addra/dina hold.
  - Last beat accepted (bytes_written reaches length): in_ready<=0 on the same edge, so no extra byte is ever taken.
  - Then -> VERIFY if verify_en, else FIN. The final write pulse still appears on the port during the next cycle.
  - in_valid gaps of any length are tolerated.
- VERIFY:
  - wea=0. Issue one read per cycle, addra = base..base+length-1.
  - A RD_LAT-deep valid shift register tags returning douta; each tagged byte is added to rd_sum.
  - After the last address is issued -> DRAIN.
- DRAIN: wait RD_LAT cycles for outstanding reads, then verify_ok<=(rd_sum==wr_sum) -> FIN.
- FIN: done=1 for exactly one cycle, busy=0 in that same cycle, -> IDLE.
- busy: high from the cycle after an accepted start until the cycle before done.
- err_range, verify_ok, bytes_written: hold until the next accepted start.
- start while busy or in FIN: ignored, no side effects.
- addra never exceeds MAX_ADDR.
- Reset mid-operation: command aborted, no further writes, no done pulse.

Test Plan:
- Basic write: base=0x0010, length=4, bytes A1,B2,C3,D4 back-to-back, verify_en=0.
  - Required: four wea pulses at 0x0010..0x0013 with matching dina.
  - done one cycle after the last write cycle; bytes_written=4; err_range=0.
- Backpressure: length=3, with in_valid low 2 cycles between each byte.
  - Required: exactly 3 writes at consecutive addresses; wea low during gaps.
  - in_ready=0 after the 3rd byte; a 4th offered byte is not accepted.
- Range: base=61440 length=2 -> err_range=1, done pulse, zero wea cycles. base=61440 length=1 -> one write at 61440, err_range=0.
- Zero length: length=0, verify_en=1 -> done within 2 cycles, no BRAM access, verify_ok=1.
- Verify with a behavioural BRAM model (RD_LAT=1), bytes 01,02,03,FF at 0x0100:
  - verify_ok=1; four reads follow the writes.
  - Repeat with the model corrupting one read byte (+1) -> verify_ok=0.
  - Repeat with RD_LAT=3 -> verify_ok=1.
- Reset mid-write: assert rst_n=0 after 2 of 5 bytes -> wea=0 asynchronously; all outputs 0; no done. A subsequent new command completes normally.

Source files
------------

// File: rtl/bram_stream_writer_if.sv
`default_nettype none
// ============================================================================
// Module   : bram_stream_writer_if
// Purpose  : Byte stream (valid/ready) plus single-port BRAM bus bundle
//            between the stream writer and its loader/BRAM neighbours.
// Revision : 1.0 - initial release
// ============================================================================
interface bram_stream_writer_if #(
   parameter int ADDR_W = 16,
   parameter int DATA_W = 8
);
   logic [DATA_W-1:0] in_data;
   logic              in_valid;
   logic              in_ready;
   logic [ADDR_W-1:0] addra;
   logic [DATA_W-1:0] dina;
   logic              wea;
   logic [DATA_W-1:0] douta;

   // Writer side: consumes the stream, drives the BRAM port.
   modport master (
      input  in_data, in_valid, douta,
      output in_ready, addra, dina, wea
   );

   // Environment side: produces the stream, implements the BRAM.
   modport slave (
      output in_data, in_valid, douta,
      input  in_ready, addra, dina, wea
   );
endinterface
`default_nettype wire

// File: rtl/bram_stream_writer.sv
`default_nettype none
// ============================================================================
// Module   : bram_stream_writer
// Purpose  : Writes a valid/ready byte stream sequentially into a single-port
//            BRAM from a programmed base, with optional readback checksum.
// Revision : 1.0 - initial release
// ============================================================================
module bram_stream_writer #(
   parameter int ADDR_W   = 16,
   parameter int DATA_W   = 8,
   parameter int MAX_ADDR = 61440,
   parameter int RD_LAT   = 1
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  start,
   input  logic [ADDR_W-1:0]     base_addr,
   input  logic [ADDR_W:0]       length,
   input  logic                  verify_en,
   bram_stream_writer_if.master  bus,
   output logic                  busy,
   output logic                  done,
   output logic                  err_range,
   output logic                  verify_ok,
   output logic [ADDR_W:0]       bytes_written
);

   // End address is formed two bits wider than the address so that
   // base+length-1 can never wrap past the range check.
   localparam int                  c_ext_w    = ADDR_W + 2;
   localparam logic [c_ext_w-1:0]  c_max_ext  = c_ext_w'(MAX_ADDR);
   localparam logic [c_ext_w-1:0]  c_one_ext  = c_ext_w'(1);
   localparam logic [ADDR_W:0]     c_one_len  = (ADDR_W+1)'(1);
   localparam logic [ADDR_W-1:0]   c_one_addr = ADDR_W'(1);

   typedef enum logic [2:0] {
      S_IDLE   = 3'd0,
      S_WRITE  = 3'd1,
      S_VERIFY = 3'd2,
      S_DRAIN  = 3'd3,
      S_FIN    = 3'd4
   } state_t;

   state_t              state_q, state_d;
   logic [ADDR_W-1:0]   base_q, base_d;
   logic [ADDR_W:0]     len_q, len_d;
   logic                ver_en_q, ver_en_d;
   logic [ADDR_W-1:0]   cur_addr_q, cur_addr_d;
   logic [ADDR_W:0]     bytes_written_q, bytes_written_d;
   logic [ADDR_W:0]     rd_cnt_q, rd_cnt_d;
   logic [DATA_W-1:0]   wr_sum_q, wr_sum_d;
   logic [DATA_W-1:0]   rd_sum_q, rd_sum_d;
   // Bit 0 marks a read address on addra; bit RD_LAT marks douta valid.
   logic [RD_LAT:0]     vld_q, vld_d;
   logic [ADDR_W-1:0]   addra_q, addra_d;
   logic [DATA_W-1:0]   dina_q, dina_d;
   logic                wea_q, wea_d;
   logic                in_ready_q, in_ready_d;
   logic                busy_q, busy_d;
   logic                done_q, done_d;
   logic                err_range_q, err_range_d;
   logic                verify_ok_q, verify_ok_d;
   logic [c_ext_w-1:0]  end_addr;

   assign end_addr = {2'b00, base_addr} + {1'b0, length} - c_one_ext;

   // Next-state and registered-output computation for the command sequencer.
   always_comb begin
      state_d         = state_q;
      base_d          = base_q;
      len_d           = len_q;
      ver_en_d        = ver_en_q;
      cur_addr_d      = cur_addr_q;
      bytes_written_d = bytes_written_q;
      rd_cnt_d        = rd_cnt_q;
      wr_sum_d        = wr_sum_q;
      rd_sum_d        = rd_sum_q;
      vld_d           = {vld_q[RD_LAT-1:0], 1'b0};
      addra_d         = addra_q;
      dina_d          = dina_q;
      wea_d           = 1'b0;
      in_ready_d      = in_ready_q;
      busy_d          = busy_q;
      done_d          = 1'b0;
      err_range_d     = err_range_q;
      verify_ok_d     = verify_ok_q;

      if (vld_q[RD_LAT]) begin
         rd_sum_d = rd_sum_q + bus.douta;
      end

      case (state_q)
         S_IDLE: begin
            if (start) begin
               base_d          = base_addr;
               len_d           = length;
               ver_en_d        = verify_en;
               cur_addr_d      = base_addr;
               bytes_written_d = '0;
               rd_cnt_d        = '0;
               wr_sum_d        = '0;
               rd_sum_d        = '0;
               err_range_d     = 1'b0;
               verify_ok_d     = 1'b0;
               busy_d          = 1'b1;
               if (length == '0) begin
                  verify_ok_d = verify_en;
                  state_d     = S_FIN;
               end else if (end_addr > c_max_ext) begin
                  err_range_d = 1'b1;
                  state_d     = S_FIN;
               end else begin
                  in_ready_d = 1'b1;
                  state_d    = S_WRITE;
               end
            end
         end

         S_WRITE: begin
            if (bus.in_valid && in_ready_q) begin
               addra_d         = cur_addr_q;
               dina_d          = bus.in_data;
               wea_d           = 1'b1;
               cur_addr_d      = cur_addr_q + c_one_addr;
               bytes_written_d = bytes_written_q + c_one_len;
               wr_sum_d        = wr_sum_q + bus.in_data;
               // Drop ready on the same edge as the final beat so no
               // extra byte can slip in.
               if (bytes_written_q + c_one_len == len_q) begin
                  in_ready_d = 1'b0;
                  state_d    = ver_en_q ? S_VERIFY : S_FIN;
               end
            end
         end

         S_VERIFY: begin
            addra_d  = base_q + rd_cnt_q[ADDR_W-1:0];
            rd_cnt_d = rd_cnt_q + c_one_len;
            vld_d[0] = 1'b1;
            if (rd_cnt_q + c_one_len == len_q) begin
               state_d = S_DRAIN;
            end
         end

         S_DRAIN: begin
            // Compare only once every tagged read has been accumulated.
            if (vld_q == '0) begin
               verify_ok_d = (rd_sum_q == wr_sum_q);
               state_d     = S_FIN;
            end
         end

         S_FIN: begin
            busy_d  = 1'b0;
            done_d  = 1'b1;
            state_d = S_IDLE;
         end

         default: begin
            state_d = S_IDLE;
         end
      endcase
   end

   // State and output registers; async reset clears wea without a clock.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q         <= S_IDLE;
         base_q          <= '0;
         len_q           <= '0;
         ver_en_q        <= 1'b0;
         cur_addr_q      <= '0;
         bytes_written_q <= '0;
         rd_cnt_q        <= '0;
         wr_sum_q        <= '0;
         rd_sum_q        <= '0;
         vld_q           <= '0;
         addra_q         <= '0;
         dina_q          <= '0;
         wea_q           <= 1'b0;
         in_ready_q      <= 1'b0;
         busy_q          <= 1'b0;
         done_q          <= 1'b0;
         err_range_q     <= 1'b0;
         verify_ok_q     <= 1'b0;
      end else begin
         state_q         <= state_d;
         base_q          <= base_d;
         len_q           <= len_d;
         ver_en_q        <= ver_en_d;
         cur_addr_q      <= cur_addr_d;
         bytes_written_q <= bytes_written_d;
         rd_cnt_q        <= rd_cnt_d;
         wr_sum_q        <= wr_sum_d;
         rd_sum_q        <= rd_sum_d;
         vld_q           <= vld_d;
         addra_q         <= addra_d;
         dina_q          <= dina_d;
         wea_q           <= wea_d;
         in_ready_q      <= in_ready_d;
         busy_q          <= busy_d;
         done_q          <= done_d;
         err_range_q     <= err_range_d;
         verify_ok_q     <= verify_ok_d;
      end
   end

   assign bus.in_ready  = in_ready_q;
   assign bus.addra     = addra_q;
   assign bus.dina      = dina_q;
   assign bus.wea       = wea_q;
   assign busy          = busy_q;
   assign done          = done_q;
   assign err_range     = err_range_q;
   assign verify_ok     = verify_ok_q;
   assign bytes_written = bytes_written_q;

endmodule
`default_nettype wire

// File: tb/tb_bram_stream_writer.sv
`default_nettype none
// ============================================================================
// Module   : tb_bram_stream_writer
// Purpose  : Directed bench for bram_stream_writer with behavioural BRAMs
//            (read latency 1 and 3 instances driven by one stream).
// Revision : 1.0 - initial release
// ============================================================================
module tb_bram_stream_writer;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        start;
   logic [15:0] base_addr;
   logic [16:0] length;
   logic        verify_en;
   logic [7:0]  in_data;
   logic        in_valid;
   logic        corrupt;

   logic        busy1, done1, err1, vok1;
   logic [16:0] bw1;
   logic        busy3, done3, err3, vok3;
   logic [16:0] bw3;

   int checks = 0;
   int errors = 0;

   bram_stream_writer_if #(.ADDR_W(16), .DATA_W(8)) bif1 ();
   bram_stream_writer_if #(.ADDR_W(16), .DATA_W(8)) bif3 ();

   bram_stream_writer #(.ADDR_W(16), .DATA_W(8), .MAX_ADDR(61440), .RD_LAT(1)) u_dut1 (
      .clk(clk), .rst_n(rst_n), .start(start), .base_addr(base_addr),
      .length(length), .verify_en(verify_en), .bus(bif1),
      .busy(busy1), .done(done1), .err_range(err1), .verify_ok(vok1),
      .bytes_written(bw1)
   );

   bram_stream_writer #(.ADDR_W(16), .DATA_W(8), .MAX_ADDR(61440), .RD_LAT(3)) u_dut3 (
      .clk(clk), .rst_n(rst_n), .start(start), .base_addr(base_addr),
      .length(length), .verify_en(verify_en), .bus(bif3),
      .busy(busy3), .done(done3), .err_range(err3), .verify_ok(vok3),
      .bytes_written(bw3)
   );

   always #5 clk = ~clk;

   assign bif1.in_data  = in_data;
   assign bif1.in_valid = in_valid;
   assign bif3.in_data  = in_data;
   assign bif3.in_valid = in_valid;

   // Latency-1 BRAM model, read-first; can corrupt the byte read at 0x0102.
   logic [7:0] mem1 [0:65535];
   logic [7:0] rd1;
   always @(posedge clk) begin
      if (bif1.wea) mem1[bif1.addra] <= bif1.dina;
      rd1 <= mem1[bif1.addra] + ((corrupt && bif1.addra == 16'h0102) ? 8'd1 : 8'd0);
   end
   assign bif1.douta = rd1;

   // Latency-3 BRAM model.
   logic [7:0] mem3 [0:65535];
   logic [7:0] p0, p1, p2;
   always @(posedge clk) begin
      if (bif3.wea) mem3[bif3.addra] <= bif3.dina;
      p0 <= mem3[bif3.addra];
      p1 <= p0;
      p2 <= p1;
   end
   assign bif3.douta = p2;

   // Port monitors for the latency-1 instance.
   logic [15:0] wlog_a [0:255];
   logic [7:0]  wlog_d [0:255];
   logic [15:0] rlog   [0:255];
   int wcnt = 0, rcnt = 0, done1_cnt = 0, done3_cnt = 0;
   int w0 = 0, r0 = 0, d3_0 = 0, exp_len = 0;
   logic rd_arm = 1'b0;

   always @(posedge clk) begin
      if (bif1.wea) begin
         wlog_a[wcnt[7:0]] <= bif1.addra;
         wlog_d[wcnt[7:0]] <= bif1.dina;
         wcnt <= wcnt + 1;
      end else if (busy1 && rd_arm && exp_len != 0 && (wcnt - w0) == exp_len) begin
         rlog[rcnt[7:0]] <= bif1.addra;
         rcnt <= rcnt + 1;
      end
      if (done1) done1_cnt <= done1_cnt + 1;
      if (done3) done3_cnt <= done3_cnt + 1;
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   task automatic cmd(input logic [15:0] b, input logic [16:0] l, input logic v);
      w0 = wcnt; r0 = rcnt; d3_0 = done3_cnt; exp_len = int'(l); rd_arm = v;
      start = 1'b1; base_addr = b; length = l; verify_en = v;
      @(negedge clk);
      start = 1'b0;
   endtask

   // Offer one byte and return at the negedge after it was accepted.
   task automatic send(input logic [7:0] b);
      int k = 0;
      in_data  = b;
      in_valid = 1'b1;
      while (!bif1.in_ready && k < 100) begin
         @(negedge clk);
         k++;
      end
      chk("accept_wait", {31'd0, (k < 100)}, 32'd1);
      @(negedge clk);
   endtask

   task automatic wait_done1(output int n);
      n = 0;
      while (!done1 && n < 200) begin
         @(negedge clk);
         n++;
      end
   endtask

   task automatic wait_done3();
      int k = 0;
      while (done3_cnt == d3_0 && k < 200) begin
         @(negedge clk);
         k++;
      end
      chk("done3_seen", done3_cnt - d3_0, 32'd1);
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1);
   end

   initial begin
      int n;
      int dsnap;
      rst_n = 1'b0; start = 1'b0; base_addr = '0; length = '0; verify_en = 1'b0;
      in_data = '0; in_valid = 1'b0; corrupt = 1'b0;
      repeat (3) @(negedge clk);

      // Reset state.
      chk("rst_ctrl", {26'd0, busy1, done1, err1, vok1, bif1.in_ready, bif1.wea}, 32'd0);
      chk("rst_addra", bif1.addra, 32'd0);
      chk("rst_dina", bif1.dina, 32'd0);
      chk("rst_bw", bw1, 32'd0);
      rst_n = 1'b1;
      @(negedge clk);

      // Basic write, back-to-back.
      cmd(16'h0010, 17'd4, 1'b0);
      chk("t1_busy", busy1, 32'd1);
      chk("t1_ready", bif1.in_ready, 32'd1);
      send(8'hA1); send(8'hB2); send(8'hC3); send(8'hD4);
      chk("t1_ready_low", bif1.in_ready, 32'd0);
      in_valid = 1'b0;
      wait_done1(n);
      chk("t1_done_lat", n, 32'd1);
      chk("t1_busy_at_done", busy1, 32'd0);
      chk("t1_bw", bw1, 32'd4);
      chk("t1_err", err1, 32'd0);
      chk("t1_nwrites", wcnt - w0, 32'd4);
      chk("t1_a0", wlog_a[w0 + 0], 32'h10); chk("t1_d0", wlog_d[w0 + 0], 32'hA1);
      chk("t1_a1", wlog_a[w0 + 1], 32'h11); chk("t1_d1", wlog_d[w0 + 1], 32'hB2);
      chk("t1_a2", wlog_a[w0 + 2], 32'h12); chk("t1_d2", wlog_d[w0 + 2], 32'hC3);
      chk("t1_a3", wlog_a[w0 + 3], 32'h13); chk("t1_d3", wlog_d[w0 + 3], 32'hD4);
      @(negedge clk);
      chk("t1_done_pulse", done1, 32'd0);

      // Backpressure: two idle cycles between bytes, fourth byte offered.
      cmd(16'h0200, 17'd3, 1'b0);
      send(8'h11);
      chk("t2_wea_hi", bif1.wea, 32'd1);
      in_valid = 1'b0;
      @(negedge clk);
      chk("t2_wea_gap", bif1.wea, 32'd0);
      @(negedge clk);
      send(8'h22);
      in_valid = 1'b0;
      repeat (2) @(negedge clk);
      send(8'h33);
      in_data = 8'h44;
      chk("t2_ready_low", bif1.in_ready, 32'd0);
      wait_done1(n);
      chk("t2_done_lat", n, 32'd1);
      @(negedge clk);
      in_valid = 1'b0;
      chk("t2_bw", bw1, 32'd3);
      chk("t2_nwrites", wcnt - w0, 32'd3);
      chk("t2_a0", wlog_a[w0 + 0], 32'h200); chk("t2_d0", wlog_d[w0 + 0], 32'h11);
      chk("t2_a1", wlog_a[w0 + 1], 32'h201); chk("t2_d1", wlog_d[w0 + 1], 32'h22);
      chk("t2_a2", wlog_a[w0 + 2], 32'h202); chk("t2_d2", wlog_d[w0 + 2], 32'h33);

      // Range: end address 61441 rejected, end address 61440 accepted.
      cmd(16'hF000, 17'd2, 1'b0);
      wait_done1(n);
      chk("t3_done_lat", n, 32'd1);
      chk("t3_err", err1, 32'd1);
      chk("t3_nwrites", wcnt - w0, 32'd0);
      @(negedge clk);
      cmd(16'hF000, 17'd1, 1'b0);
      send(8'h5A);
      in_valid = 1'b0;
      wait_done1(n);
      chk("t3b_err", err1, 32'd0);
      chk("t3b_nwrites", wcnt - w0, 32'd1);
      chk("t3b_a0", wlog_a[w0], 32'hF000);
      chk("t3b_d0", wlog_d[w0], 32'h5A);
      @(negedge clk);

      // Zero length with verify: immediate completion, no BRAM access.
      cmd(16'h0300, 17'd0, 1'b1);
      wait_done1(n);
      chk("t4_done_lat", n, 32'd1);
      chk("t4_vok", vok1, 32'd1);
      chk("t4_err", err1, 32'd0);
      chk("t4_nwrites", wcnt - w0, 32'd0);
      chk("t4_addra_hold", bif1.addra, 32'hF000);
      @(negedge clk);

      // Verify pass: latency 1 and latency 3 instances.
      cmd(16'h0100, 17'd4, 1'b1);
      send(8'h01); send(8'h02); send(8'h03); send(8'hFF);
      in_valid = 1'b0;
      wait_done1(n);
      chk("t5_done_seen", {31'd0, (n < 200)}, 32'd1);
      chk("t5_vok1", vok1, 32'd1);
      chk("t5_nwrites", wcnt - w0, 32'd4);
      chk("t5_r0", rlog[r0 + 0], 32'h100);
      chk("t5_r1", rlog[r0 + 1], 32'h101);
      chk("t5_r2", rlog[r0 + 2], 32'h102);
      chk("t5_r3", rlog[r0 + 3], 32'h103);
      wait_done3();
      chk("t5_vok3", vok3, 32'd1);
      @(negedge clk);

      // Verify fail: latency-1 model returns 0x04 instead of 0x03.
      corrupt = 1'b1;
      cmd(16'h0100, 17'd4, 1'b1);
      send(8'h01); send(8'h02); send(8'h03); send(8'hFF);
      in_valid = 1'b0;
      wait_done1(n);
      chk("t6_vok1", vok1, 32'd0);
      chk("t6_bw", bw1, 32'd4);
      wait_done3();
      chk("t6_vok3", vok3, 32'd1);
      corrupt = 1'b0;
      @(negedge clk);

      // Reset while the second of five writes is on the BRAM port.
      cmd(16'h0400, 17'd5, 1'b0);
      send(8'h61); send(8'h62);
      chk("t7_wea_before", bif1.wea, 32'd1);
      dsnap = done1_cnt;
      #2 rst_n = 1'b0;
      #1;
      in_valid = 1'b0;
      chk("t7_wea_async", bif1.wea, 32'd0);
      chk("t7_ctrl", {27'd0, busy1, done1, err1, vok1, bif1.in_ready}, 32'd0);
      chk("t7_addra", bif1.addra, 32'd0);
      chk("t7_dina", bif1.dina, 32'd0);
      chk("t7_bw", bw1, 32'd0);
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      repeat (5) @(negedge clk);
      chk("t7_no_done", done1_cnt - dsnap, 32'd0);
      // Only the first byte's write was clocked into the BRAM before reset.
      chk("t7_nwrites", wcnt - w0, 32'd1);

      // New command after reset completes normally.
      cmd(16'h0500, 17'd2, 1'b1);
      send(8'h10); send(8'h20);
      in_valid = 1'b0;
      wait_done1(n);
      chk("t8_vok1", vok1, 32'd1);
      chk("t8_bw", bw1, 32'd2);
      chk("t8_nwrites", wcnt - w0, 32'd2);
      chk("t8_a0", wlog_a[w0 + 0], 32'h500);
      chk("t8_a1", wlog_a[w0 + 1], 32'h501);
      wait_done3();
      chk("t8_vok3", vok3, 32'd1);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
`default_nettype wire
